// File: rtl/sdram_bist_pkg.sv
// ============================================================
// sdram_bist_pkg : shared mode codes, FSM states and LFSR step
// Rev 1.0
// ============================================================
`default_nettype none

package sdram_bist_pkg;

    localparam logic [1:0] c_MODE_INCR = 2'd0;
    localparam logic [1:0] c_MODE_ADDR = 2'd1;
    localparam logic [1:0] c_MODE_WALK = 2'd2;
    localparam logic [1:0] c_MODE_LFSR = 2'd3;

    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_NEXT = 3'd2,
        ST_RD_SEED = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_NEXT = 3'd6,
        ST_DONE    = 3'd7
    } bist_state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_bist_pattern_gen.sv
// ============================================================
// bist_pattern_gen : test pattern for a word index; owns the LFSR
// Rev 1.0
// ============================================================
`default_nettype none

module bist_pattern_gen
    import sdram_bist_pkg::*;
#(
    parameter int          ADDR_W    = 23,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W:0]   idx_i,
    input  logic [ADDR_W-1:0] lo_i,
    output logic [DATA_W-1:0] pattern_o
);

    localparam logic [ADDR_W:0] c_DW = (ADDR_W+1)'(DATA_W);

    logic [31:0]     lfsr_q;
    logic [ADDR_W:0] w_sum;
    logic [ADDR_W:0] w_bit;

    // Register always holds the value for the current word: load yields word 0
    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            lfsr_q <= lfsr_next(LFSR_SEED);
        end else if (load_i) begin
            lfsr_q <= lfsr_next(LFSR_SEED);
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign w_sum = {1'b0, lo_i} + idx_i;
    assign w_bit = idx_i % c_DW;

    always_comb begin
        pattern_o = '0;
        case (mode_i)
            c_MODE_INCR: pattern_o = DATA_W'(idx_i);
            c_MODE_ADDR: pattern_o = DATA_W'(w_sum);
            c_MODE_WALK: pattern_o = DATA_W'(1) << w_bit;
            default:     pattern_o = DATA_W'(lfsr_q);
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sdram_bist.sv
// ============================================================
// sdram_bist : SDRAM write/read-back self-test engine
// Rev 1.0
// ============================================================
`default_nettype none

module sdram_bist
    import sdram_bist_pkg::*;
#(
    parameter int          ADDR_W       = 23,
    parameter int          DATA_W       = 32,
    parameter int          ERR_W        = 16,
    parameter logic [31:0] LFSR_SEED    = 32'hACE12468,
    parameter int          RD_TIMEOUT   = 1024,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic                clk100,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   addr_lo,
    input  logic [ADDR_W-1:0]   addr_hi,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [DATA_W-1:0]   fail_exp,
    output logic [DATA_W-1:0]   fail_got,
    input  logic                cmd_ready,
    output logic                cmd_enable,
    output logic                cmd_wr,
    output logic [DATA_W/8-1:0] cmd_byte_enable,
    output logic [ADDR_W-1:0]   cmd_address,
    output logic [DATA_W-1:0]   cmd_data_in,
    input  logic [DATA_W-1:0]   data_out,
    input  logic                data_out_ready
);

    localparam int              TMR_W   = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] c_TMO  = TMR_W'(RD_TIMEOUT - 1);

    bist_state_t       state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
    logic              timeout_q, timeout_d;
    logic              valid_q, valid_d;
    logic              result_q, result_d;

    logic              w_load, w_step, w_err;
    logic [DATA_W-1:0] w_got;
    logic [DATA_W-1:0] w_pattern;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    bist_pattern_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_pattern (
        .clk100    (clk100),
        .rst       (rst),
        .load_i    (w_load),
        .step_i    (w_step),
        .mode_i    (mode_q),
        .idx_i     (idx_q),
        .lo_i      (lo_q),
        .pattern_o (w_pattern)
    );

    assign w_addr = lo_q + idx_q[ADDR_W-1:0];
    assign w_last = (w_addr == hi_q);

    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            err_count_q <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            timeout_q   <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            err_count_q <= err_count_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            timeout_q   <= timeout_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        err_count_d = err_count_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        timeout_d   = timeout_q;
        valid_d     = valid_q;
        result_d    = result_q;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_err       = 1'b0;
        w_got       = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    lo_d        = addr_lo;
                    hi_d        = addr_hi;
                    idx_d       = '0;
                    err_count_d = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    timeout_d   = 1'b0;
                    result_d    = 1'b0;
                    w_load      = 1'b1;
                    valid_d     = (addr_hi >= addr_lo);
                    state_d     = (addr_hi >= addr_lo) ? ST_WR_REQ : ST_DONE;
                end
            end
            ST_WR_REQ: begin
                if (cmd_ready) state_d = ST_WR_NEXT;
            end
            ST_WR_NEXT: begin
                if (w_last) begin
                    idx_d   = '0;
                    state_d = ST_RD_SEED;
                end else begin
                    idx_d   = idx_q + (ADDR_W+1)'(1);
                    w_step  = 1'b1;
                    state_d = ST_WR_REQ;
                end
            end
            ST_RD_SEED: begin
                w_load  = 1'b1;
                state_d = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (cmd_ready) begin
                    timer_d = '0;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (data_out_ready) begin
                    w_err   = (data_out != w_pattern);
                    w_got   = data_out;
                    state_d = ST_RD_NEXT;
                end else if (timer_q == c_TMO) begin
                    w_err     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_RD_NEXT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (w_err && STOP_ON_FAIL) state_d = ST_DONE;
            end
            ST_RD_NEXT: begin
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + (ADDR_W+1)'(1);
                    w_step  = 1'b1;
                    state_d = ST_RD_REQ;
                end
            end
            ST_DONE: begin
                result_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A zero count means no error has been latched yet this run
        if (w_err) begin
            if (err_count_q == '0) begin
                fail_addr_d = w_addr;
                fail_exp_d  = w_pattern;
                fail_got_d  = w_got;
            end
            if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
        end
    end

    assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done            = (state_q == ST_DONE);
    assign pass            = (done || result_q) && valid_q && (err_count_q == '0);
    assign timeout         = timeout_q;
    assign err_count       = err_count_q;
    assign fail_addr       = fail_addr_q;
    assign fail_exp        = fail_exp_q;
    assign fail_got        = fail_got_q;
    assign cmd_enable      = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    assign cmd_wr          = (state_q == ST_WR_REQ);
    assign cmd_byte_enable = '1;
    assign cmd_address     = w_addr;
    assign cmd_data_in     = w_pattern;

endmodule

`default_nettype wire

// File: tb/tb_sdram_bist.sv
// ============================================================
// tb_sdram_bist : scoreboard bench with a randomized controller model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_sdram_bist;

    localparam logic [31:0] SEED = 32'hACE12468;

    typedef struct {
        bit          wr;
        int          addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        bit          pass;
        int          err;
        bit          tmo;
        int          faddr;
        logic [31:0] fexp;
        logic [31:0] fgot;
    } res_t;

    logic        clk100;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [22:0] addr_lo, addr_hi;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [22:0] fail_addr;
    logic [31:0] fail_exp, fail_got;
    logic        cmd_ready, cmd_enable, cmd_wr;
    logic [3:0]  cmd_byte_enable;
    logic [22:0] cmd_address;
    logic [31:0] cmd_data_in, data_out;
    logic        data_out_ready;

    sdram_bist dut (
        .clk100          (clk100),
        .rst             (rst),
        .start           (start),
        .mode            (mode),
        .addr_lo         (addr_lo),
        .addr_hi         (addr_hi),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .err_count       (err_count),
        .fail_addr       (fail_addr),
        .fail_exp        (fail_exp),
        .fail_got        (fail_got),
        .cmd_ready       (cmd_ready),
        .cmd_enable      (cmd_enable),
        .cmd_wr          (cmd_wr),
        .cmd_byte_enable (cmd_byte_enable),
        .cmd_address     (cmd_address),
        .cmd_data_in     (cmd_data_in),
        .data_out        (data_out),
        .data_out_ready  (data_out_ready)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          done_cnt = 0;
    int          acc_cnt  = 0;
    cmd_t        exp_cmd[$];
    res_t        exp_res[$];
    logic [31:0] mem [int];
    logic [31:0] flip_mask [int];
    bit          drop_set [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] galois(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Reference: expected command stream and final result from the test rules
    task automatic expect_run(input logic [1:0] m, input int lo, input int hi);
        res_t        r;
        cmd_t        c;
        logic [31:0] s, d, got;
        logic [31:0] pats[$];
        bit          bad;
        r.pass = 0; r.err = 0; r.tmo = 0; r.faddr = 0; r.fexp = 0; r.fgot = 0;
        if (hi < lo) begin
            exp_res.push_back(r);
            return;
        end
        s = SEED;
        for (int i = 0; i <= hi - lo; i++) begin
            s = galois(s);
            case (m)
                2'd0:    d = 32'(i);
                2'd1:    d = 32'(lo + i);
                2'd2:    d = 32'd1 << (i % 32);
                default: d = s;
            endcase
            pats.push_back(d);
            c.wr = 1; c.addr = lo + i; c.data = d;
            exp_cmd.push_back(c);
        end
        for (int i = 0; i <= hi - lo; i++) begin
            c.wr = 0; c.addr = lo + i; c.data = 0;
            exp_cmd.push_back(c);
            bad = 0; got = 0;
            if (drop_set.exists(lo + i)) begin
                bad = 1; r.tmo = 1;
            end else if (flip_mask.exists(lo + i)) begin
                got = pats[i] ^ flip_mask[lo + i];
                bad = (flip_mask[lo + i] != 0);
            end
            if (bad) begin
                if (r.err == 0) begin
                    r.faddr = lo + i; r.fexp = pats[i]; r.fgot = got;
                end
                r.err++;
            end
        end
        r.pass = (r.err == 0);
        exp_res.push_back(r);
    endtask

    // Controller model: random ready gaps, read latency 3..8, fault injection
    initial begin
        int gap, lat, raddr;
        bit pend;
        gap = 0; lat = 0; raddr = 0; pend = 0;
        cmd_ready = 0; data_out_ready = 0; data_out = 0;
        forever begin
            @(negedge clk100);
            if (rst && cmd_enable && cmd_ready) begin
                if (cmd_wr) mem[int'(cmd_address)] = cmd_data_in;
                else if (!drop_set.exists(int'(cmd_address))) begin
                    pend = 1; lat = $urandom_range(3, 8); raddr = int'(cmd_address);
                end
                gap = $urandom_range(0, 5);
            end
            @(posedge clk100);
            #1;
            data_out_ready = 0;
            data_out = $urandom;
            if (!rst) begin
                pend = 0; gap = 0; cmd_ready = 0;
            end else begin
                if (pend) begin
                    lat--;
                    if (lat == 0) begin
                        pend = 0;
                        data_out_ready = 1;
                        data_out = mem[raddr] ^ (flip_mask.exists(raddr) ? flip_mask[raddr] : 32'h0);
                    end
                end
                cmd_ready = (gap == 0);
                if (gap > 0) gap--;
            end
        end
    end

    // Monitor: pops expected commands on accept, expected results on done
    initial begin
        cmd_t c;
        res_t r;
        forever begin
            @(negedge clk100);
            if (rst) begin
                if (cmd_enable && exp_cmd.size() == 0) begin
                    chk("unexpected_cmd", {63'd0, cmd_enable}, 64'd0);
                end else if (cmd_enable && cmd_ready) begin
                    acc_cnt++;
                    c = exp_cmd.pop_front();
                    chk("cmd_wr", {63'd0, cmd_wr}, {63'd0, c.wr});
                    chk("cmd_addr", {41'd0, cmd_address}, 64'(c.addr));
                    if (c.wr) chk("cmd_data", {32'd0, cmd_data_in}, {32'd0, c.data});
                end
                if (done) begin
                    done_cnt++;
                    if (exp_res.size() == 0) begin
                        chk("unexpected_done", {63'd0, done}, 64'd0);
                    end else begin
                        r = exp_res.pop_front();
                        chk("pass", {63'd0, pass}, {63'd0, r.pass});
                        chk("err_count", {48'd0, err_count}, 64'(r.err));
                        chk("timeout", {63'd0, timeout}, {63'd0, r.tmo});
                        chk("fail_addr", {41'd0, fail_addr}, 64'(r.faddr));
                        chk("fail_exp", {32'd0, fail_exp}, {32'd0, r.fexp});
                        chk("fail_got", {32'd0, fail_got}, {32'd0, r.fgot});
                        chk("busy_at_done", {63'd0, busy}, 64'd0);
                    end
                end
            end
        end
    end

    task automatic run(input logic [1:0] m, input int lo, input int hi, input bit extra);
        int d0, k;
        d0 = done_cnt;
        expect_run(m, lo, hi);
        @(posedge clk100); #1;
        start = 1; mode = m; addr_lo = 23'(lo); addr_hi = 23'(hi);
        @(posedge clk100); #1;
        start = 0; mode = 2'($urandom); addr_lo = 23'($urandom); addr_hi = 23'($urandom);
        chk("busy_after_start", {63'd0, busy}, {63'd0, (hi >= lo)});
        chk("cmd_en_after_start", {63'd0, cmd_enable}, {63'd0, (hi >= lo)});
        chk("done_after_start", {63'd0, done}, {63'd0, (hi < lo)});
        if (extra) begin
            repeat (5) @(posedge clk100);
            #1; start = 1;
            @(posedge clk100); #1; start = 0;
        end
        k = 0;
        while (done_cnt == d0 && k < 20000) begin
            @(posedge clk100);
            k++;
        end
        if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
        repeat (10) @(posedge clk100);
        chk("done_once", 64'(done_cnt - d0), 64'd1);
        chk("cmds_drained", 64'(exp_cmd.size()), 64'd0);
        flip_mask.delete();
        drop_set.delete();
    endtask

    initial begin
        int a0, n, lo;
        rst = 0; start = 0; mode = 0; addr_lo = 0; addr_hi = 0;
        repeat (3) @(posedge clk100);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_err", {48'd0, err_count}, 64'd0);
        chk("rst_fail_addr", {41'd0, fail_addr}, 64'd0);
        chk("rst_cmd_en", {63'd0, cmd_enable}, 64'd0);
        chk("rst_cmd_wr", {63'd0, cmd_wr}, 64'd0);
        chk("rst_cmd_addr", {41'd0, cmd_address}, 64'd0);
        chk("rst_cmd_data", {32'd0, cmd_data_in}, 64'd0);
        chk("rst_byte_en", {60'd0, cmd_byte_enable}, 64'hF);
        @(negedge clk100);
        rst = 1;

        run(2'd0, 0, 15, 0);
        flip_mask['h102] = 32'h10;
        run(2'd1, 'h100, 'h103, 0);
        a0 = acc_cnt;
        run(2'd3, 'h7FFFFF, 'h7FFFFF, 0);
        chk("T3_accepts", 64'(acc_cnt - a0), 64'd2);
        chk("T3_word", {32'd0, mem['h7FFFFF]}, {32'd0, galois(SEED)});
        drop_set[5] = 1;
        run(2'd2, 0, 39, 0);
        run(2'd0, 10, 9, 0);
        run(2'd0, 0, 15, 1);

        for (int t = 0; t < 6; t++) begin
            n  = $urandom_range(1, 20);
            lo = $urandom_range(0, (1 << 23) - 1 - n);
            if ($urandom_range(0, 1) == 1)
                flip_mask[lo + $urandom_range(0, n - 1)] = 32'd1 << $urandom_range(0, 31);
            run(2'($urandom_range(0, 3)), lo, lo + n - 1, 0);
        end

        // Reset in the middle of a write pass
        expect_run(2'd0, 0, 15);
        @(posedge clk100); #1;
        start = 1; mode = 0; addr_lo = 0; addr_hi = 15;
        @(posedge clk100); #1; start = 0;
        repeat (12) @(posedge clk100);
        #3; rst = 0;
        #1;
        chk("T6_cmd_en", {63'd0, cmd_enable}, 64'd0);
        chk("T6_busy", {63'd0, busy}, 64'd0);
        exp_cmd.delete();
        exp_res.delete();
        @(negedge clk100);
        chk("T6_err", {48'd0, err_count}, 64'd0);
        chk("T6_done", {63'd0, done}, 64'd0);
        repeat (2) @(posedge clk100);
        #2; rst = 1;
        run(2'd0, 0, 15, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
